// File: rtl/b20_filter_check.sv
// b20_filter_check
//   Forward Crypto1 filter evaluator and checker for 20-bit filter-input
//   candidates. Each accepted KEY20 (enumerator bit order) is bit-reversed
//   into k20, split into five nibbles, passed through fa/fb to form the 5-bit
//   Fc input, and then through Fc to give the filter bit and the rank of the
//   Fc input within its preimage list. Results are compared against the
//   expected (bit, IDX) and per-run statistics are kept.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             1-cycle pulse: flush pipeline, clear stats, latch exp_bit
//   exp_bit           expected filter bit, sampled on start
//   key_valid/ready   input handshake for key20
//   key20             candidate, enumerator bit order
//   out_valid/ready   output handshake
//   out_bit           filter output bit
//   out_sel           Fc input {fa(n4),fb(n3),fa(n2),fa(n1),fb(n0)}
//   out_rank          rank of out_sel in the Fc preimage list for out_bit
//   out_key           key20 that produced this result
//   count             results consumed this run (never exceeds NUM_KEYS)
//   errors            mismatches this run, saturating
//   first_err_key     key20 of the first mismatch, 0 if none
//   err               sticky: errors != 0
//   done              sticky: count reached NUM_KEYS
module b20_filter_check #(
  parameter logic [3:0]  IDX      = 4'd0,
  parameter int unsigned NUM_KEYS = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        exp_bit,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [19:0] key20,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_bit,
  output logic [4:0]  out_sel,
  output logic [3:0]  out_rank,
  output logic [19:0] out_key,
  output logic [15:0] count,
  output logic [15:0] errors,
  output logic [19:0] first_err_key,
  output logic        err,
  output logic        done
);

  localparam logic [15:0] FA_TBL     = 16'h9E98;
  localparam logic [15:0] FB_TBL     = 16'hB48E;
  localparam logic [31:0] FC_TBL     = 32'hEC57E80A;
  localparam logic [15:0] LAST_COUNT = 16'(NUM_KEYS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t      state;
  logic        exp_q;
  logic        s1_valid;
  logic [4:0]  s1_sel;
  logic [19:0] s1_key;

  logic [19:0] k20;
  logic [4:0]  sel_in;
  logic        s2_hold;
  logic        s1_hold;
  logic        accept;
  logic        take;
  logic        mismatch;

  // Rank of each Fc input among the inputs sharing its Fc output value.
  function automatic logic [3:0] rank_of(input logic [4:0] s);
    logic [3:0] r;
    case (s)
      5'd0:  r = 4'd0;   5'd1:  r = 4'd0;   5'd2:  r = 4'd1;   5'd3:  r = 4'd1;
      5'd4:  r = 4'd2;   5'd5:  r = 4'd3;   5'd6:  r = 4'd4;   5'd7:  r = 4'd5;
      5'd8:  r = 4'd6;   5'd9:  r = 4'd7;   5'd10: r = 4'd8;   5'd11: r = 4'd2;
      5'd12: r = 4'd9;   5'd13: r = 4'd3;   5'd14: r = 4'd4;   5'd15: r = 4'd5;
      5'd16: r = 4'd6;   5'd17: r = 4'd7;   5'd18: r = 4'd8;   5'd19: r = 4'd10;
      5'd20: r = 4'd9;   5'd21: r = 4'd11;  5'd22: r = 4'd10;  5'd23: r = 4'd12;
      5'd24: r = 4'd13;  5'd25: r = 4'd14;  5'd26: r = 4'd11;  5'd27: r = 4'd12;
      5'd28: r = 4'd15;  5'd29: r = 4'd13;  5'd30: r = 4'd14;  default: r = 4'd15;
    endcase
    return r;
  endfunction

  always_comb begin
    k20 = '0;
    for (int unsigned i = 0; i < 20; i++) begin
      k20[i] = key20[19 - i];
    end
  end

  always_comb begin
    sel_in = {FA_TBL[k20[19:16]], FB_TBL[k20[15:12]], FA_TBL[k20[11:8]],
              FA_TBL[k20[7:4]], FB_TBL[k20[3:0]]};
  end

  // S1 only stalls when it holds data that S2 cannot take; an empty S1 keeps
  // accepting keys even while S2 is stalled, so nothing is dropped.
  assign s2_hold   = out_valid & ~out_ready;
  assign s1_hold   = s1_valid & s2_hold;
  assign key_ready = (state == ST_RUN) & ~s1_hold;
  assign accept    = key_valid & key_ready;
  assign take      = out_valid & out_ready;
  assign mismatch  = (out_bit != exp_q) | (out_rank != IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      exp_q         <= 1'b0;
      s1_valid      <= 1'b0;
      s1_sel        <= '0;
      s1_key        <= '0;
      out_valid     <= 1'b0;
      out_bit       <= 1'b0;
      out_sel       <= '0;
      out_rank      <= '0;
      out_key       <= '0;
      count         <= '0;
      errors        <= '0;
      first_err_key <= '0;
      err           <= 1'b0;
      done          <= 1'b0;
    end else if (start) begin
      state         <= ST_RUN;
      exp_q         <= exp_bit;
      s1_valid      <= 1'b0;
      out_valid     <= 1'b0;
      count         <= '0;
      errors        <= '0;
      first_err_key <= '0;
      err           <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (!s2_hold) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_sel  <= s1_sel;
          out_bit  <= FC_TBL[s1_sel];
          out_rank <= rank_of(s1_sel);
          out_key  <= s1_key;
        end
      end
      if (!s1_hold) begin
        s1_valid <= accept;
        if (accept) begin
          s1_sel <= sel_in;
          s1_key <= key20;
        end
      end
      // Results drained while in DONE are consumed but leave the stats alone.
      if (take && state == ST_RUN) begin
        count <= count + 16'd1;
        if (mismatch) begin
          if (errors != '1) begin
            errors <= errors + 16'd1;
          end
          if (errors == '0) begin
            first_err_key <= out_key;
          end
          err <= 1'b1;
        end
        if (count == LAST_COUNT) begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_b20_filter_check.sv
// Bench for b20_filter_check: three instances (IDX 0, 5, 15) share stimulus.
// Expected results are queued when a key is accepted; a negedge monitor pops
// and compares them when the IDX=5 instance hands a result over.
module tb_b20_filter_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, exp_bit, key_valid, out_ready;
  logic [19:0] key20;

  logic        key_ready_a [3];
  logic        out_valid_a [3];
  logic        out_bit_a   [3];
  logic        err_a       [3];
  logic        done_a      [3];
  logic [4:0]  out_sel_a   [3];
  logic [3:0]  out_rank_a  [3];
  logic [19:0] out_key_a   [3];
  logic [19:0] first_a     [3];
  logic [15:0] count_a     [3];
  logic [15:0] errors_a    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [3:0] IDXV = (g == 0) ? 4'd0 : (g == 1) ? 4'd5 : 4'd15;
    b20_filter_check #(.IDX(IDXV), .NUM_KEYS(32768)) u_dut (
      .clk(clk), .reset(reset), .start(start), .exp_bit(exp_bit),
      .key_valid(key_valid), .key_ready(key_ready_a[g]), .key20(key20),
      .out_valid(out_valid_a[g]), .out_ready(out_ready), .out_bit(out_bit_a[g]),
      .out_sel(out_sel_a[g]), .out_rank(out_rank_a[g]), .out_key(out_key_a[g]),
      .count(count_a[g]), .errors(errors_a[g]), .first_err_key(first_a[g]),
      .err(err_a[g]), .done(done_a[g])
    );
  end

  logic key_ready, out_valid;
  assign key_ready = key_ready_a[1];
  assign out_valid = out_valid_a[1];

  typedef struct {
    logic [19:0] key;
    logic [4:0]  sel;
    logic        b;
    logic [3:0]  rank;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned rdy_mode = 0;
  logic        chk_stall = 1'b0;
  logic [3:0]  fa0 [8];
  logic [3:0]  fa1 [8];
  logic [3:0]  fb1 [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Keys whose Fc input is 15 (bit 1, rank 5): fa(n4)=0, fb(n3)=1, fa(n2)=1, fa(n1)=1, fb(n0)=1.
  function automatic logic [19:0] gen_key(input int unsigned i);
    logic [19:0] k, r;
    k = {fa0[(i / 4096) % 8], fb1[(i / 512) % 8], fa1[(i / 64) % 8],
         fa1[(i / 8) % 8], fb1[i % 8]};
    for (int unsigned j = 0; j < 20; j++) r[j] = k[19 - j];
    return r;
  endfunction

  // Output readiness: 0 = always ready, 1 = random 50%, 2 = never ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && !start && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got key %05h, required no output", out_key_a[1]);
      end else begin
        e = sb.pop_front();
        if (out_key_a[1] !== e.key || out_sel_a[1] !== e.sel ||
            out_bit_a[1] !== e.b || out_rank_a[1] !== e.rank) begin
          miscompares++;
          $display("FAIL result: got key=%05h sel=%0d bit=%0d rank=%0d, required key=%05h sel=%0d bit=%0d rank=%0d",
                   out_key_a[1], out_sel_a[1], out_bit_a[1], out_rank_a[1],
                   e.key, e.sel, e.b, e.rank);
        end
      end
    end
    if (chk_stall && !reset && !start && !key_ready) begin
      vectors++;
      if (!(out_valid && !out_ready)) begin
        miscompares++;
        $display("FAIL stall_ready: got key_ready=0 with out_valid=%0d out_ready=%0d, required a stalled output",
                 out_valid, out_ready);
      end
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic send(input logic [19:0] k, input logic [4:0] s, input logic b, input logic [3:0] r);
    exp_t e;
    bit   ok = 1'b0;
    key_valid = 1'b1;
    key20     = k;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      if (key_ready) begin
        e.key = k; e.sel = s; e.b = b; e.rank = r;
        sb.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    key_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_start(input logic eb);
    start     = 1'b1;
    exp_bit   = eb;
    key_valid = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0 = 0, c1 = 0, cb = 0;
    logic [15:0] fa_c, fb_c;
    fa_c = 16'h9E98;
    fb_c = 16'hB48E;
    for (int n = 0; n < 16; n++) begin
      if (fa_c[n]) begin fa1[c1] = 4'(n); c1++; end
      else         begin fa0[c0] = 4'(n); c0++; end
      if (fb_c[n]) begin fb1[cb] = 4'(n); cb++; end
    end

    reset = 1'b1; start = 1'b0; exp_bit = 1'b0; key_valid = 1'b0; key20 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", key_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count_a[1], 0);
    chk("rst_errors", errors_a[1], 0);
    chk("rst_done_err", {done_a[1], err_a[1]}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_key_ready", key_ready, 0);

    // Directed vectors with EXP_BIT=0; latency of the first key
    do_start(1'b0);
    send(20'h00000, 5'd0, 1'b0, 4'd0);
    @(negedge clk);
    chk("lat_t1_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_t2_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    chk("k0_count_idx0", count_a[0], 1);
    chk("k0_errors_idx0", errors_a[0], 0);
    chk("k0_err_idx0", err_a[0], 0);
    send(20'hFFFFF, 5'd31, 1'b1, 4'd15);
    send(20'h80000, 5'd1, 1'b1, 4'd0);
    wait_drain(50);
    chk("dir_count_idx0", count_a[0], 3);
    chk("dir_errors_idx0", errors_a[0], 2);
    chk("dir_first_idx0", first_a[0], 20'hFFFFF);

    // EXP_BIT=1: key 0 mismatches on the bit, key FFFFF matches only for IDX=15
    do_start(1'b1);
    send(20'h00000, 5'd0, 1'b0, 4'd0);
    send(20'hFFFFF, 5'd31, 1'b1, 4'd15);
    wait_drain(50);
    chk("e1_errors_idx15", errors_a[2], 1);
    chk("e1_err_idx15", err_a[2], 1);
    chk("e1_first_idx15", first_a[2], 20'h00000);
    chk("e1_count_idx15", count_a[2], 2);
    chk("e1_errors_idx0", errors_a[0], 2);

    // Full enumeration for sel 15, always ready
    do_start(1'b1);
    chk_stall = 1'b1;
    for (int unsigned i = 0; i < 32768; i++) send(gen_key(i), 5'd15, 1'b1, 4'd5);
    chk_stall = 1'b0;
    for (int n = 0; n < 100 && !done_a[1]; n++) begin
      @(posedge clk);
      #1;
    end
    wait_drain(50);
    chk("full_done", done_a[1], 1);
    chk("full_count", count_a[1], 32768);
    chk("full_errors", errors_a[1], 0);
    chk("full_err", err_a[1], 0);
    chk("full_key_ready_done", key_ready, 0);
    chk("full_errors_idx0", errors_a[0], 32768);
    chk("full_first_idx0", first_a[0], gen_key(0));
    chk("full_errors_idx15", errors_a[2], 32768);

    // Same key stream under random backpressure
    do_start(1'b1);
    rdy_mode  = 1;
    chk_stall = 1'b1;
    for (int unsigned i = 0; i < 3000; i++) send(gen_key(i * 7 + 3), 5'd15, 1'b1, 4'd5);
    chk_stall = 1'b0;
    wait_drain(20000);
    rdy_mode = 0;
    chk("bp_count", count_a[1], 3000);
    chk("bp_errors", errors_a[1], 0);
    chk("bp_done", done_a[1], 0);

    // START with two results in flight
    do_start(1'b1);
    for (int unsigned i = 0; i < 100; i++) send(gen_key(i), 5'd15, 1'b1, 4'd5);
    wait_drain(50);
    chk("flush_pre_count", count_a[1], 100);
    rdy_mode = 2;
    repeat (2) begin @(posedge clk); #1; end
    send(gen_key(200), 5'd15, 1'b1, 4'd5);
    send(gen_key(201), 5'd15, 1'b1, 4'd5);
    @(posedge clk);
    #1;
    chk("flush_in_flight", out_valid, 1);
    rdy_mode = 0;
    do_start(1'b1);
    chk("flush_count", count_a[1], 0);
    repeat (3) begin
      chk("flush_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end

    // RESET mid-run, asserted together with START
    do_start(1'b0);
    for (int unsigned i = 0; i < 10; i++) send(gen_key(i), 5'd15, 1'b1, 4'd5);
    wait_drain(50);
    chk("pre_rst_errors", errors_a[1], 10);
    chk("pre_rst_first", first_a[1], gen_key(0));
    rdy_mode = 2;
    repeat (2) begin @(posedge clk); #1; end
    send(gen_key(11), 5'd15, 1'b1, 4'd5);
    send(gen_key(12), 5'd15, 1'b1, 4'd5);
    reset = 1'b1; start = 1'b1; key_valid = 1'b1; key20 = 20'hFFFFF;
    @(posedge clk);
    #1;
    sb.delete();
    chk("mrst_key_ready", key_ready, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_count", count_a[1], 0);
    chk("mrst_errors", errors_a[1], 0);
    chk("mrst_first", first_a[1], 0);
    chk("mrst_done_err", {done_a[1], err_a[1]}, 0);
    chk("mrst_out_fields", {out_bit_a[1], out_sel_a[1], out_rank_a[1], out_key_a[1]}, 0);
    reset = 1'b0; start = 1'b0; rdy_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("mrst_idle_key_ready", key_ready, 0);
      chk("mrst_idle_count", count_a[1], 0);
    end
    key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
